// File: rtl/ex_stage_if.sv
// Signal bundle between the execute stage and its ID/MEM/data-SRAM neighbours.
// master = upstream/controller side, slave = ex_stage.
interface ex_stage_if;
   logic [5:0]   stall;
   logic [172:0] id_to_ex_bus;
   logic [75:0]  ex_to_mem_bus;
   logic [37:0]  ex_to_id_bus;
   logic         loading;
   logic         stallreq_for_ex;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_id_bus, loading, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );
   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_id_bus, loading, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU/shifts, data-SRAM request, HI/LO and an iterative divider.
// Define EX_MULT_EN to enable single-cycle MULT/MULTU; otherwise they are NOPs.
module ex_stage #(
   parameter int          DIV_ITER = 32,
   parameter logic [31:0] HILO_RST = 32'h0
) (
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave bus
);
   localparam int CW = $clog2(DIV_ITER + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   logic [172:0] ex_r;
   logic [13:0]  sl_bus;
   logic [31:0]  pc, inst, rdata1, rdata2;
   logic [11:0]  alu_op;
   logic [2:0]   src1_sel;
   logic [3:0]   src2_sel, ram_wen;
   logic         ram_en, rf_we_in, sel_rf_res;
   logic [4:0]   waddr_in;
   logic         load;

   assign {sl_bus, pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen,
           rf_we_in, waddr_in, sel_rf_res, rdata1, rdata2} = ex_r;

   // stall[2] free: take ID's payload; stall[2] stuck but stall[3] free: inject a bubble.
   assign load = !bus.stall[2] || !bus.stall[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                ex_r <= '0;
      else if (!bus.stall[2]) ex_r <= bus.id_to_ex_bus;
      else if (!bus.stall[3]) ex_r <= '0;
   end

   logic [31:0] imm_sext, src1, src2, alu_res, result, hi, lo;
   logic [5:0]  funct;
   logic        is_r, is_div, div_sgn, is_mfhi, is_mflo, is_mthi, is_mtlo, rf_we;
   logic [4:0]  rf_waddr;

   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign src1 = ({32{src1_sel[0]}} & rdata1) | ({32{src1_sel[1]}} & pc)
               | ({32{src1_sel[2]}} & {27'd0, inst[10:6]});
   assign src2 = ({32{src2_sel[0]}} & rdata2) | ({32{src2_sel[1]}} & imm_sext)
               | ({32{src2_sel[2]}} & 32'd8) | ({32{src2_sel[3]}} & {16'd0, inst[15:0]});

   // alu_op bit order: add sub slt sltu and nor or xor sll srl sra lui (MSB..LSB)
   always_comb begin
      alu_res = '0;
      if (alu_op[11]) alu_res = src1 + src2;
      if (alu_op[10]) alu_res = src1 - src2;
      if (alu_op[9])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
      if (alu_op[8])  alu_res = {31'd0, src1 < src2};
      if (alu_op[7])  alu_res = src1 & src2;
      if (alu_op[6])  alu_res = ~(src1 | src2);
      if (alu_op[5])  alu_res = src1 | src2;
      if (alu_op[4])  alu_res = src1 ^ src2;
      if (alu_op[3])  alu_res = src2 << src1[4:0];
      if (alu_op[2])  alu_res = src2 >> src1[4:0];
      if (alu_op[1])  alu_res = $signed(src2) >>> src1[4:0];
      if (alu_op[0])  alu_res = {src2[15:0], 16'h0};
   end

   assign funct   = inst[5:0];
   assign is_r    = inst[31:26] == 6'd0;
   assign is_div  = is_r && (funct == 6'h1a || funct == 6'h1b);
   assign div_sgn = !funct[0];
   assign is_mfhi = is_r && funct == 6'h10;
   assign is_mthi = is_r && funct == 6'h11;
   assign is_mflo = is_r && funct == 6'h12;
   assign is_mtlo = is_r && funct == 6'h13;

   assign result   = is_mfhi ? hi : is_mflo ? lo : alu_res;
   assign rf_we    = rf_we_in || is_mfhi || is_mflo;
   assign rf_waddr = (is_mfhi || is_mflo) ? inst[15:11] : waddr_in;

`ifdef EX_MULT_EN
   logic        is_mult;
   logic [63:0] prod;
   assign is_mult = is_r && funct[5:1] == 5'b01100;
   // Sign-extending to 64 bits makes the low 64 product bits the signed result.
   assign prod = funct[0] ? {32'd0, rdata1} * {32'd0, rdata2}
                          : {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
`endif

   // Divider: magnitudes are divided, signs applied in DONE.
   div_state_t  state, state_nx;
   logic [CW-1:0] cnt;
   logic [31:0] quo, rem, dvs;
   logic        q_neg, r_neg, dz, div_done, stallreq, geq;
   logic [32:0] rem_sh, rem_sub;

   assign rem_sh  = {rem, quo[31]};
   assign rem_sub = rem_sh - {1'b0, dvs};
   assign geq     = rem_sh >= {1'b0, dvs};

   always_comb begin
      state_nx = state;
      stallreq = 1'b0;
      case (state)
         IDLE: if (is_div && !div_done) begin
            state_nx = RUN;
            stallreq = 1'b1;
         end
         RUN: begin
            stallreq = 1'b1;
            if (cnt == CW'(DIV_ITER - 1)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == RUN) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= (div_sgn && rdata1[31]) ? -rdata1 : rdata1;
            dvs   <= (div_sgn && rdata2[31]) ? -rdata2 : rdata2;
            q_neg <= div_sgn && (rdata1[31] ^ rdata2[31]);
            r_neg <= div_sgn && rdata1[31];
            dz    <= rdata2 == 32'd0;
         end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            quo <= {quo[30:0], geq};
            rem <= geq ? rem_sub[31:0] : rem_sh[31:0];
         end
      end
   end

   // With a zero divisor the remainder path leaves |rs|, so the dividend sign restores rs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi       <= HILO_RST;
         lo       <= HILO_RST;
         div_done <= 1'b0;
      end else begin
         if (state == DONE) begin
            lo       <= dz ? 32'hFFFF_FFFF : (q_neg ? -quo : quo);
            hi       <= r_neg ? -rem : rem;
            div_done <= 1'b1;
         end
         if (is_mthi) hi <= rdata1;
         if (is_mtlo) lo <= rdata1;
`ifdef EX_MULT_EN
         if (is_mult) {hi, lo} <= prod;
`endif
         if (load) div_done <= 1'b0;
      end
   end

   assign bus.ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result};
   assign bus.ex_to_id_bus    = {rf_we, rf_waddr, result};
   assign bus.loading         = sl_bus[13];
   assign bus.stallreq_for_ex = stallreq;
   assign bus.data_sram_en    = ram_en;
   assign bus.data_sram_wen   = ram_wen;
   assign bus.data_sram_addr  = rdata1 + imm_sext;
   assign bus.data_sram_wdata = rdata2;

   logic unused_bits;
   assign unused_bits = ^{sl_bus[12:0], inst[25:16], bus.stall[5:4], bus.stall[1:0]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, memory request, HI/LO moves, divider timing and reset.
module tb_ex_stage;
   localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                           OP_SLTU = 12'h100, OP_NOR = 12'h040, OP_OR = 12'h020,
                           OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
   localparam logic [31:0] PC = 32'hBFC0_0100;

   logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
   logic [5:0] stall_base = '0;
   int n_chk = 0, n_pass = 0;

   ex_stage_if bus();
   ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;
   // Controller: the divider request freezes IF..EX and MEM-reg, like the core's ctrl block.
   assign bus.stall = (bus.stallreq_for_ex || hold) ? 6'b001111 : stall_base;

   task automatic chk(input string tag, input logic [75:0] act, input logic [75:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   function automatic logic [172:0] mk(input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ren, input logic [3:0] wen,
      input logic we, input logic [4:0] wa, input logic lw, input logic [31:0] r1, r2);
      mk = {lw, 13'd0, PC, inst, op, s1, s2, ren, wen, we, wa, lw, r1, r2};
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] sa);
      rtype = {6'd0, 5'd1, 5'd2, rd, sa, fn};
   endfunction

   task automatic issue(input logic [172:0] v);
      stall_base = '0;
      bus.id_to_ex_bus = v;
      @(posedge clk); #1;
   endtask

   task automatic rd_hilo(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
      issue(mk(rtype(6'h10, 5'd9, 5'd0), '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0));
      chk({tag, "_hi"}, 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd9, hi_e}));
      issue(mk(rtype(6'h12, 5'd10, 5'd0), '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0));
      chk({tag, "_lo"}, 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd10, lo_e}));
   endtask

   task automatic hilo_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      issue(mk(rtype(fn, 5'd0, 5'd0), '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, a, b));
   endtask

   // Issues a divide and waits out the busy window; returns in the DONE cycle.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
      int n = 0;
      hilo_op(sgn ? 6'h1a : 6'h1b, a, b);
      bus.id_to_ex_bus = '0;
      while (bus.stallreq_for_ex && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk({tag, "_stall_cycles"}, 76'(n), 76'd33);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bus.id_to_ex_bus = mk(rtype(6'h21, 5'd5, 5'd0), OP_ADD, 3'b001, 4'b0001, 1'b1, 4'hF,
                            1'b1, 5'd5, 1'b1, 32'h1234, 32'h5678);
      repeat (2) @(posedge clk); #1;
      chk("rst_mem_bus", bus.ex_to_mem_bus, '0);
      chk("rst_id_bus", 76'(bus.ex_to_id_bus), '0);
      chk("rst_flags", 76'({bus.loading, bus.stallreq_for_ex}), '0);
      chk("rst_sram", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                          bus.data_sram_wdata}), '0);
      @(negedge clk) rst = 1'b0;

      issue(mk(rtype(6'h21, 5'd5, 5'd0), OP_ADD, 3'b001, 4'b0001, 1'b0, '0, 1'b1, 5'd5, 1'b0,
               32'h7FFF_FFFF, 32'h1));
      chk("addu_id", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd5, 32'h8000_0000}));
      chk("addu_mem", bus.ex_to_mem_bus, {PC, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000});
      issue(mk(rtype(6'h2b, 5'd6, 5'd0), OP_SLTU, 3'b001, 4'b0001, 1'b0, '0, 1'b1, 5'd6, 1'b0,
               32'h1, 32'hFFFF_FFFF));
      chk("sltu", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd6, 32'h1}));
      issue(mk(rtype(6'h2a, 5'd6, 5'd0), OP_SLT, 3'b001, 4'b0001, 1'b0, '0, 1'b1, 5'd6, 1'b0,
               32'h1, 32'hFFFF_FFFF));
      chk("slt", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd6, 32'h0}));
      issue(mk(rtype(6'h23, 5'd7, 5'd0), OP_SUB, 3'b001, 4'b0001, 1'b0, '0, 1'b1, 5'd7, 1'b0,
               32'd5, 32'd7));
      chk("subu", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd7, 32'hFFFF_FFFE}));
      issue(mk(rtype(6'h03, 5'd8, 5'd4), OP_SRA, 3'b100, 4'b0001, 1'b0, '0, 1'b1, 5'd8, 1'b0,
               32'h0, 32'h8000_0000));
      chk("sra", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd8, 32'hF800_0000}));
      issue(mk(rtype(6'h02, 5'd8, 5'd4), OP_SRL, 3'b100, 4'b0001, 1'b0, '0, 1'b1, 5'd8, 1'b0,
               32'h0, 32'h8000_0000));
      chk("srl", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd8, 32'h0800_0000}));
      issue(mk({6'h0f, 5'd0, 5'd3, 16'h1234}, OP_LUI, 3'b000, 4'b1000, 1'b0, '0, 1'b1, 5'd3,
               1'b0, 32'h0, 32'h0));
      chk("lui", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd3, 32'h1234_0000}));
      issue(mk({6'h0d, 5'd1, 5'd3, 16'h000F}, OP_OR, 3'b001, 4'b1000, 1'b0, '0, 1'b1, 5'd3,
               1'b0, 32'hF0, 32'h0));
      chk("ori", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd3, 32'hFF}));
      issue(mk(rtype(6'h27, 5'd4, 5'd0), OP_NOR, 3'b001, 4'b0001, 1'b0, '0, 1'b1, 5'd4, 1'b0,
               32'h0, 32'h0));
      chk("nor", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd4, 32'hFFFF_FFFF}));

      // stall[2]=stall[3]=Stop holds; stall[2] alone injects a bubble.
      bus.id_to_ex_bus = mk(rtype(6'h21, 5'd5, 5'd0), OP_ADD, 3'b001, 4'b0001, 1'b1, 4'hF,
                            1'b1, 5'd5, 1'b1, 32'h1, 32'h1);
      stall_base = 6'b001100;
      @(posedge clk); #1;
      chk("stall_hold", 76'(bus.ex_to_id_bus), 76'({1'b1, 5'd4, 32'hFFFF_FFFF}));
      stall_base = 6'b000100;
      @(posedge clk); #1;
      chk("bubble_id", 76'(bus.ex_to_id_bus), '0);
      chk("bubble_mem", 76'({bus.data_sram_en, bus.loading, bus.ex_to_mem_bus[43]}), '0);

      issue(mk({6'h23, 5'd1, 5'd5, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd5,
               1'b1, 32'h100, 32'h0));
      chk("lw_sram", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr}),
          76'({1'b1, 4'h0, 32'hFC}));
      chk("lw_loading", 76'(bus.loading), 76'd1);
      chk("lw_mem_bus", bus.ex_to_mem_bus, {PC, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'hFC});
      issue(mk({6'h2b, 5'd1, 5'd5, 16'h0008}, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
               1'b0, 32'h200, 32'hDEAD_BEEF));
      chk("sw_sram", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                         bus.data_sram_wdata}), 76'({1'b1, 4'hF, 32'h208, 32'hDEAD_BEEF}));
      chk("sw_loading", 76'(bus.loading), 76'd0);

      hilo_op(6'h11, 32'h1111_1111, 32'h0);
      hilo_op(6'h13, 32'h2222_2222, 32'h0);
      rd_hilo("mthi_mtlo", 32'h1111_1111, 32'h2222_2222);

      hilo_op(6'h18, 32'hFFFF_FFFF, 32'h2);
      chk("mult_no_stall", 76'(bus.stallreq_for_ex), 76'd0);
`ifdef EX_MULT_EN
      rd_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`else
      rd_hilo("mult_nop", 32'h1111_1111, 32'h2222_2222);
`endif

      run_div("divu", 1'b0, 32'd100, 32'd7);
      rd_hilo("divu", 32'd2, 32'd14);
      run_div("div_pn", 1'b1, 32'd7, 32'hFFFF_FFFE);
      rd_hilo("div_pn", 32'd1, 32'hFFFF_FFFD);
      run_div("div_np", 1'b1, 32'hFFFF_FFF9, 32'd2);
      rd_hilo("div_np", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_div("div_z", 1'b1, 32'h10, 32'h0);
      rd_hilo("div_z", 32'h10, 32'hFFFF_FFFF);

      // MEM-side hold keeps the divide in EX after DONE: it must not restart.
      run_div("div_hold", 1'b0, 32'd100, 32'd7);
      hold = 1'b1;
      n = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.stallreq_for_ex) n++;
      end
      chk("div_hold_restall", 76'(n), 76'd0);
      hold = 1'b0;
      rd_hilo("div_hold", 32'd2, 32'd14);

      hilo_op(6'h1a, 32'h1000, 32'd3);
      bus.id_to_ex_bus = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("div_run_busy", 76'(bus.stallreq_for_ex), 76'd1);
      rst = 1'b1;
      #1;
      chk("rst_run_stallreq", 76'(bus.stallreq_for_ex), 76'd0);
      @(negedge clk) rst = 1'b0;
      rd_hilo("rst_run", 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
